// File: rtl/instr_fetch_unit.sv
// Fetch-and-issue front end: walks PC, fetches 24-bit words over req/ack, holds them in IR and counts issues.
// Optional HALT support (opcode 4'b1111 stops fetching) is built when IFU_HALT_EN is defined.
module instr_fetch_unit #(
    parameter int PC_W  = 12,
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             ResetN,
    output logic             ImemReq,
    output logic [PC_W-1:0]  ImemAddr,
    input  logic [23:0]      ImemRdata,
    input  logic             ImemAck,
    output logic             InstrValid,
    input  logic             IssueReady,
    input  logic             BranchTaken,
    output logic [3:0]       OPCODE,
    output logic [3:0]       Rs,
    output logic [3:0]       Rt,
    output logic [3:0]       Rd,
    output logic [3:0]       Function,
    output logic [11:0]      Imm,
    output logic [PC_W-1:0]  PC,
    output logic [CNT_W-1:0] InstrCount,
    output logic             Halted
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
`ifdef IFU_HALT_EN
    localparam logic [1:0] ST_HALT  = 2'd2;
`endif

    logic [1:0]       state_r;
    logic [23:0]      ir_r;
    logic [PC_W-1:0]  pc_r;
    logic [CNT_W-1:0] count_r;
    logic             req_r;
    logic             valid_r;
    logic             fetch_ack_s;
    logic             issue_s;
    logic [PC_W-1:0]  offset_s;
    logic [PC_W-1:0]  next_pc_s;

    // Sign-extend the 12-bit immediate, then fit it to the PC width (modulo arithmetic).
    function automatic logic [PC_W-1:0] sext_imm(input logic [11:0] imm);
        logic [63:0] wide;
        wide = {{52{imm[11]}}, imm};
        return wide[PC_W-1:0];
    endfunction

    // Handshake qualifiers and the next-PC computation.
    always_comb begin
        fetch_ack_s = (state_r == ST_FETCH) && req_r && ImemAck;
        issue_s     = (state_r == ST_ISSUE) && valid_r && IssueReady;
        if (BranchTaken) begin
            offset_s = sext_imm(ir_r[11:0]);
        end else begin
            offset_s = {PC_W{1'b0}};
        end
        next_pc_s = pc_r + PC_W'(1'b1) + offset_s;
    end

    // Fetch/issue state machine; req and valid are registered so reset drops them asynchronously.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_r <= ST_FETCH;
            ir_r    <= 24'h000000;
            pc_r    <= {PC_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            req_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (fetch_ack_s) begin
                        ir_r    <= ImemRdata;
                        req_r   <= 1'b0;
                        valid_r <= 1'b1;
                        state_r <= ST_ISSUE;
                    end else begin
                        req_r   <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (issue_s) begin
                        pc_r    <= next_pc_s;
                        count_r <= count_r + CNT_W'(1'b1);
                        valid_r <= 1'b0;
`ifdef IFU_HALT_EN
                        if (ir_r[23:20] == 4'hF) begin
                            state_r <= ST_HALT;
                            req_r   <= 1'b0;
                        end else begin
                            state_r <= ST_FETCH;
                            req_r   <= 1'b1;
                        end
`else
                        state_r <= ST_FETCH;
                        req_r   <= 1'b1;
`endif
                    end
                end
`ifdef IFU_HALT_EN
                ST_HALT: begin
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                end
`endif
                default: begin
                    state_r <= ST_FETCH;
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign ImemReq    = req_r;
    assign ImemAddr   = pc_r;
    assign InstrValid = valid_r;
    assign PC         = pc_r;
    assign InstrCount = count_r;
    assign OPCODE     = ir_r[23:20];
    assign Rs         = ir_r[19:16];
    assign Rt         = ir_r[15:12];
    assign Rd         = ir_r[11:8];
    assign Function   = ir_r[3:0];
    assign Imm        = ir_r[11:0];
`ifdef IFU_HALT_EN
    assign Halted     = (state_r == ST_HALT);
`else
    assign Halted     = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: table of fetch/issue vectors checked through a scoreboard queue,
// plus hand sequences for mid-fetch reset and the opcode-F (HALT) case.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
    localparam int PC_W  = 12;
    localparam int CNT_W = 16;

    logic             Clock = 1'b0;
    logic             ResetN = 1'b0;
    logic             ImemReq;
    logic [PC_W-1:0]  ImemAddr;
    logic [23:0]      ImemRdata = 24'h000000;
    logic             ImemAck = 1'b0;
    logic             InstrValid;
    logic             IssueReady = 1'b0;
    logic             BranchTaken = 1'b0;
    logic [3:0]       OPCODE, Rs, Rt, Rd, Function;
    logic [11:0]      Imm;
    logic [PC_W-1:0]  PC;
    logic [CNT_W-1:0] InstrCount;
    logic             Halted;

    instr_fetch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .Clock(Clock), .ResetN(ResetN), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemRdata(ImemRdata), .ImemAck(ImemAck), .InstrValid(InstrValid),
        .IssueReady(IssueReady), .BranchTaken(BranchTaken), .OPCODE(OPCODE),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .Function(Function), .Imm(Imm), .PC(PC),
        .InstrCount(InstrCount), .Halted(Halted)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [23:0] word;
        int          waits;
        int          stall;
        logic        br;
        logic [31:0] fields;   // {OPCODE,Rs,Rt,Rd,Function,Imm}
        logic [11:0] pc;
        logic [11:0] nxt;
        logic [15:0] cnt;
        logic        req;
        logic        halt;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    vec_t sb_q[$];
    vec_t vecs[8];
    vec_t hv[3];

    function automatic vec_t mk(input logic [23:0] word, input int waits, input int stall,
                                input logic br, input logic [3:0] op, input logic [3:0] rs,
                                input logic [3:0] rt, input logic [3:0] rd, input logic [3:0] fn,
                                input logic [11:0] imm, input logic [11:0] pc, input logic [11:0] nxt,
                                input logic [15:0] cnt, input logic req, input logic halt);
        vec_t v;
        v.word = word; v.waits = waits; v.stall = stall; v.br = br;
        v.fields = {op, rs, rt, rd, fn, imm};
        v.pc = pc; v.nxt = nxt; v.cnt = cnt; v.req = req; v.halt = halt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge Clock);
    endtask

    // Memory side: wait for a request, hold off ack for v.waits cycles, then return the word.
    task automatic serve(input vec_t v);
        int n;
        logic [PC_W-1:0] a0;
        n = 0;
        ImemAck = 1'b0;
        while (!ImemReq && n < 20) begin
            step();
            n++;
        end
        chk("req_up", 32'(ImemReq), 32'd1);
        a0 = ImemAddr;
        chk("fetch_addr", 32'(ImemAddr), 32'(v.pc));
        for (int w = 0; w < v.waits; w++) begin
            ImemRdata = 24'($urandom);
            step();
            chk("wait_req", 32'(ImemReq), 32'd1);
            chk("wait_addr", 32'(ImemAddr), 32'(a0));
            chk("wait_valid", 32'(InstrValid), 32'd0);
        end
        ImemAck = 1'b1;
        ImemRdata = v.word;
        sb_q.push_back(v);
        step();
        ImemAck = 1'b0;
        ImemRdata = 24'($urandom);
    endtask

    // Datapath side: pop the expected instruction, stall, then complete the issue handshake.
    task automatic issue();
        vec_t e;
        chk("valid_up", 32'(InstrValid), 32'd1);
        chk("req_low", 32'(ImemReq), 32'd0);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            for (int s = 0; s <= e.stall; s++) begin
                chk("fields", {OPCODE, Rs, Rt, Rd, Function, Imm}, e.fields);
                chk("issue_pc", 32'(PC), 32'(e.pc));
                if (s < e.stall) begin
                    IssueReady = 1'b0;
                    BranchTaken = 1'($urandom);
                    step();
                    chk("stall_valid", 32'(InstrValid), 32'd1);
                    chk("stall_req", 32'(ImemReq), 32'd0);
                end
            end
            IssueReady = 1'b1;
            BranchTaken = e.br;
            step();
            IssueReady = 1'b0;
            BranchTaken = 1'b0;
            chk("post_valid", 32'(InstrValid), 32'd0);
            chk("post_req", 32'(ImemReq), 32'(e.req));
            chk("next_pc", 32'(PC), 32'(e.nxt));
            chk("next_addr", 32'(ImemAddr), 32'(e.nxt));
            chk("count", 32'(InstrCount), 32'(e.cnt));
            chk("halted", 32'(Halted), 32'(e.halt));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //               word        w  s  br  op    rs    rt    rd    fn    imm      pc       nxt      cnt  req   halt
        vecs[0] = mk(24'h612305, 0, 0, 1'b0, 4'h6, 4'h1, 4'h2, 4'h3, 4'h5, 12'h305, 12'h000, 12'h001, 16'd1, 1'b1, 1'b0);
        vecs[1] = mk(24'h1A4B07, 3, 0, 1'b0, 4'h1, 4'hA, 4'h4, 4'hB, 4'h7, 12'hB07, 12'h001, 12'h002, 16'd2, 1'b1, 1'b0);
        vecs[2] = mk(24'h234567, 0, 5, 1'b0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 12'h567, 12'h002, 12'h003, 16'd3, 1'b1, 1'b0);
        vecs[3] = mk(24'h300006, 0, 0, 1'b1, 4'h3, 4'h0, 4'h0, 4'h0, 4'h6, 12'h006, 12'h003, 12'h00A, 16'd4, 1'b1, 1'b0);
        vecs[4] = mk(24'h4C0FFC, 0, 0, 1'b1, 4'h4, 4'hC, 4'h0, 4'hF, 4'hC, 12'hFFC, 12'h00A, 12'h007, 16'd5, 1'b1, 1'b0);
        vecs[5] = mk(24'h500FF7, 1, 0, 1'b1, 4'h5, 4'h0, 4'h0, 4'hF, 4'h7, 12'hFF7, 12'h007, 12'hFFF, 16'd6, 1'b1, 1'b0);
        vecs[6] = mk(24'h789002, 0, 0, 1'b1, 4'h7, 4'h8, 4'h9, 4'h0, 4'h2, 12'h002, 12'hFFF, 12'h002, 16'd7, 1'b1, 1'b0);
        vecs[7] = mk(24'h8ABCDE, 2, 2, 1'b0, 4'h8, 4'hA, 4'hB, 4'hC, 4'hE, 12'hCDE, 12'h002, 12'h003, 16'd8, 1'b1, 1'b0);
        hv[0] = mk(24'h000000, 0, 0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 12'h000, 12'h000, 12'h001, 16'd1, 1'b1, 1'b0);
        hv[1] = mk(24'h000000, 0, 0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 12'h000, 12'h001, 12'h002, 16'd2, 1'b1, 1'b0);
`ifdef IFU_HALT_EN
        hv[2] = mk(24'hF00000, 0, 0, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 12'h000, 12'h002, 12'h003, 16'd3, 1'b0, 1'b1);
`else
        hv[2] = mk(24'hF00000, 0, 0, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 12'h000, 12'h002, 12'h003, 16'd3, 1'b1, 1'b0);
`endif

        // Reset state: ack and ready asserted during reset must be ignored.
        ImemAck = 1'b1;
        IssueReady = 1'b1;
        step();
        step();
        chk("rst_req", 32'(ImemReq), 32'd0);
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_pc", 32'(PC), 32'd0);
        chk("rst_cnt", 32'(InstrCount), 32'd0);
        chk("rst_fields", {OPCODE, Rs, Rt, Rd, Function, Imm}, 32'd0);
        chk("rst_halted", 32'(Halted), 32'd0);
        ImemAck = 1'b0;
        IssueReady = 1'b0;
        ResetN = 1'b1;

        for (int i = 0; i < 8; i++) begin
            serve(vecs[i]);
            issue();
        end

        // Reset while a fetch is outstanding: req drops at once, restart from 0.
        ImemAck = 1'b0;
        step();
        step();
        chk("pre_rst_req", 32'(ImemReq), 32'd1);
        ResetN = 1'b0;
        #1;
        chk("async_req", 32'(ImemReq), 32'd0);
        chk("async_cnt", 32'(InstrCount), 32'd0);
        chk("async_addr", 32'(ImemAddr), 32'd0);
        step();
        ResetN = 1'b1;
        step();
        chk("restart_req", 32'(ImemReq), 32'd1);
        chk("restart_addr", 32'(ImemAddr), 32'd0);

        // Opcode F at address 2: halts with the macro, fetches address 3 without it.
        for (int i = 0; i < 3; i++) begin
            serve(hv[i]);
            issue();
        end
`ifdef IFU_HALT_EN
        ImemAck = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("halt_req", 32'(ImemReq), 32'd0);
            chk("halt_flag", 32'(Halted), 32'd1);
            chk("halt_valid", 32'(InstrValid), 32'd0);
        end
        ImemAck = 1'b0;
        chk("halt_cnt", 32'(InstrCount), 32'd3);
        chk("halt_pc", 32'(PC), 32'd3);
`else
        step();
        chk("nohalt_req", 32'(ImemReq), 32'd1);
        chk("nohalt_addr", 32'(ImemAddr), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch-and-issue front end for the 24-bit single-cycle CPU. Walks the program counter, fetches 24-bit instructions from instruction memory over a req/ack handshake, and holds each one in an instruction register. The register is split into the OPCODE/Function/register/immediate fields that drive the control unit and datapath. Applies branch redirects reported back by the datapath and counts issued instructions.

## Interface
Parameters:
- PC_W, 12, program-counter and instruction-memory address width (word-addressed, one word = one 24-bit instruction)
- CNT_W, 16, width of the issued-instruction counter

Ports:
- Clock  in  1  single clock, rising edge
- ResetN  in  1  reset, asynchronous, active-low
- ImemReq  out  1  fetch request
- ImemAddr  out  PC_W  fetch address, equal to PC
- ImemRdata  in  24  instruction word, valid when ImemAck=1
- ImemAck  in  1  memory accepts request and returns data this cycle
- InstrValid  out  1  decoded fields are valid
- IssueReady  in  1  datapath consumes the current instruction
- BranchTaken  in  1  sampled on the issue handshake; redirect to the branch target
- OPCODE  out  4  IR[23:20]
- Rs  out  4  IR[19:16]
- Rt  out  4  IR[15:12]
- Rd  out  4  IR[11:8]
- Function  out  4  IR[3:0]
- Imm  out  12  IR[11:0]
- PC  out  PC_W  address of the instruction in IR
- InstrCount  out  CNT_W  number of issue handshakes completed
- Halted  out  1  HALT reached (feature-dependent, see Configuration)

## Operation
- FSM states:
  - FETCH: ImemReq=1 and ImemAddr=PC, both held stable until ImemAck.
    - On ImemAck: IR <= ImemRdata, then go to ISSUE.
  - ISSUE: InstrValid=1; fields are combinational slices of IR.
    - On InstrValid & IssueReady (the handshake):
      - PC <= BranchTaken ? PC + 1 + sext(Imm) : PC + 1.
      - InstrCount <= InstrCount + 1.
      - Go to FETCH.
  - HALT: exists only with the macro enabled. ImemReq=0, InstrValid=0, Halted=1. Left only by reset.
- Arithmetic: all PC arithmetic is modulo 2^PC_W, so PC wraps from all-ones to 0.
  - sext(Imm) is Imm sign-extended from bit 11, then truncated or extended to PC_W.
  - InstrCount wraps modulo 2^CNT_W.
- BranchTaken and IssueReady are ignored outside ISSUE.
- ImemAck is ignored when ImemReq=0.
- ImemRdata is ignored unless ImemAck=1 in FETCH.
- Reset values: state FETCH, PC=0, IR=0, InstrCount=0. All outputs are 0, except that ImemReq rises to 1 in the first cycle after ResetN deasserts.
- Reset mid-operation: an outstanding fetch is abandoned and an in-flight IR is discarded. ImemReq drops immediately, asynchronously with ResetN low.

## Timing
- Fetch latency: with ImemAck in the same cycle ImemReq rises (cycle t), InstrValid=1 in cycle t+1.
- Wait states: each cycle without ImemAck adds one cycle. ImemAddr must not change while waiting.
- Issue: InstrValid stays high, with IR, PC and fields stable, until IssueReady is seen.
  - The handshake edge updates PC and InstrCount.
  - InstrValid is 0 and ImemReq is 1 in the following cycle.
- Peak throughput: one instruction per 2 cycles (zero-wait memory, IssueReady held high).
- Simultaneous BranchTaken and IssueReady: the branch target is taken; the counter still increments by 1.
- The IR changes only on an accepted fetch.

## Configuration
- IFU_HALT_EN defined: opcode 4'b1111 is HALT.
  - On its issue handshake, PC and InstrCount update as normal (PC + 1) and the FSM goes to HALT.
  - Halted=1 from the next cycle; no further fetches.
- IFU_HALT_EN undefined:
  - Opcode 4'b1111 issues like any other instruction.
  - HALT state is not built; Halted is tied to 0.

## Test plan
- Reset, zero-wait memory, IssueReady=1, IMEM[0]=24'h612305:
  - ImemAddr=0 in cycle 1, InstrValid in cycle 2.
  - OPCODE=6, Rs=1, Rt=2, Rd=3, Function=5.
  - PC then 1; InstrCount=1.
- Memory acks after 3 wait cycles:
  - ImemAddr and ImemReq stay constant for 4 cycles.
  - InstrValid rises 1 cycle after the ack.
- IssueReady low for 5 cycles in ISSUE: fields and PC stable, no new ImemReq. Handshake on cycle 6 gives PC+1.
- Branch redirect:
  - PC=10, Imm=12'hFFC, BranchTaken=1 at handshake -> next ImemAddr=7.
  - PC=12'hFFF, Imm=12'h002 -> ImemAddr=2 (wrap).
- ResetN pulsed low while waiting for ImemAck:
  - ImemReq=0 at once.
  - After release, fetch restarts at address 0 with InstrCount=0.
- With IFU_HALT_EN, IMEM[2]=24'hF00000:
  - After its handshake, Halted=1 and ImemReq stays 0 for 20 cycles.
  - InstrCount=3, PC=3.
  - Without the macro, address 3 is fetched next.
